// File: rtl/aes_kat_sequencer.sv
// Known-answer self-test sequencer: reads a vector ROM, drives an external AES core, scores results.
// Optional macro AES_KAT_DECRYPT_EN adds a decrypt round trip to every vector.
module aes_kat_sequencer #(
  parameter  int NUM_VECTORS    = 4,
  parameter  int KEY_W          = 256,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int IW             = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
  localparam int CW             = $clog2(NUM_VECTORS + 1)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  output logic [IW-1:0]    vec_addr_o,
  input  logic [127:0]     vec_plain_i,
  input  logic [127:0]     vec_cipher_i,
  input  logic [KEY_W-1:0] vec_key_i,
  output logic             core_v_o,
  input  logic             core_ready_i,
  output logic [127:0]     core_data_o,
  output logic [KEY_W-1:0] core_key_o,
  output logic             core_decrypt_o,
  input  logic             core_v_i,
  input  logic [127:0]     core_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CW-1:0]    fail_count_o,
  output logic [IW-1:0]    first_fail_o,
  output logic             timeout_o
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VECTORS - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT, CHECK, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [127:0]       plain_q, plain_d;
  logic [127:0]       cipher_q, cipher_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [127:0]       res_q, res_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic               vec_fail_q, vec_fail_d;
  logic [CW-1:0]      fail_cnt_q, fail_cnt_d;
  logic [IW-1:0]      first_fail_q, first_fail_d;
  logic               timeout_q, timeout_d;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      plain_q      <= '0;
      cipher_q     <= '0;
      key_q        <= '0;
      res_q        <= '0;
      tmr_q        <= '0;
      vec_fail_q   <= 1'b0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      plain_q      <= plain_d;
      cipher_q     <= cipher_d;
      key_q        <= key_d;
      res_q        <= res_d;
      tmr_q        <= tmr_d;
      vec_fail_q   <= vec_fail_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    plain_d      = plain_q;
    cipher_d     = cipher_q;
    key_d        = key_q;
    res_d        = res_q;
    tmr_d        = tmr_q;
    vec_fail_d   = vec_fail_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    timeout_d    = timeout_q;
    core_v_o     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          fail_cnt_d   = '0;
          first_fail_d = '0;
          timeout_d    = 1'b0;
          idx_d        = '0;
          state_d      = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        plain_d    = vec_plain_i;
        cipher_d   = vec_cipher_i;
        key_d      = vec_key_i;
        vec_fail_d = 1'b0;
        state_d    = ENC_REQ;
      end
      ENC_REQ: begin
        core_v_o = 1'b1;
        if (core_ready_i) begin
          tmr_d   = TMO_LOAD;
          state_d = ENC_WAIT;
        end
      end
      ENC_WAIT: begin
        // A response on the last timer cycle still wins over the timeout.
        if (core_v_i) begin
          res_d = core_data_i;
          if (core_data_i != cipher_q) vec_fail_d = 1'b1;
`ifdef AES_KAT_DECRYPT_EN
          state_d = DEC_REQ;
`else
          state_d = CHECK;
`endif
        end else if (tmr_q == '0) begin
          vec_fail_d = 1'b1;
          timeout_d  = 1'b1;
          state_d    = CHECK;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      DEC_REQ: begin
        core_v_o = 1'b1;
        if (core_ready_i) begin
          tmr_d   = TMO_LOAD;
          state_d = DEC_WAIT;
        end
      end
      DEC_WAIT: begin
        if (core_v_i) begin
          res_d = core_data_i;
          if (core_data_i != plain_q) vec_fail_d = 1'b1;
          state_d = CHECK;
        end else if (tmr_q == '0) begin
          vec_fail_d = 1'b1;
          timeout_d  = 1'b1;
          state_d    = CHECK;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      CHECK: begin
        if (vec_fail_q) begin
          fail_cnt_d = fail_cnt_q + 1'b1;
          if (fail_cnt_q == '0) first_fail_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AES_KAT_DECRYPT_EN
  assign core_decrypt_o = (state_q == DEC_REQ);
`else
  assign core_decrypt_o = 1'b0;
`endif

  // Decrypt requests carry the encrypt result; everything else carries the latched plaintext.
  assign core_data_o  = (state_q == DEC_REQ) ? res_q : plain_q;
  assign core_key_o   = key_q;
  assign vec_addr_o   = idx_q;
  assign busy_o       = (state_q != IDLE) && (state_q != DONE);
  assign done_o       = (state_q == DONE);
  assign pass_o       = (state_q == DONE) && (fail_cnt_q == '0);
  assign fail_count_o = fail_cnt_q;
  assign first_fail_o = first_fail_q;
  assign timeout_o    = timeout_q;

endmodule

// File: doc/aes_kat_sequencer.md
AES_KAT_SEQUENCER -- requirements
Module: aes_kat_sequencer

Interface
REQ-001 Parameter NUM_VECTORS, default 4: number of known-answer vectors, legal range 1..256.
REQ-002 Parameter KEY_W, default 256: key width; legal values are only 128, 192 and 256.
REQ-003 Parameter TIMEOUT_CYCLES, default 64: maximum cycles to wait for a core response, at least 2.
REQ-004 Port clk_i  in  1: single clock; all state updates on the rising edge.
REQ-005 Port reset_n_i  in  1: reset, asynchronous and active-low.
REQ-006 Port start_i  in  1: one-cycle pulse that starts a self-test run.
REQ-007 Port vec_addr_o  out  IW=max(1,$clog2(NUM_VECTORS)): vector ROM read address.
REQ-008 Ports vec_plain_i, vec_cipher_i  in  128 each; vec_key_i  in  KEY_W: ROM data, valid one cycle after vec_addr_o.
REQ-009 Ports core_v_o  out  1 and core_ready_i  in  1: request handshake; the transfer completes when both are high.
REQ-010 Ports core_data_o  out  128, core_key_o  out  KEY_W, core_decrypt_o  out  1: request payload to the AES core.
REQ-011 Ports core_v_i  in  1 and core_data_i  in  128: core result, valid for one cycle.
REQ-012 Ports busy_o, done_o, pass_o  out  1 each: run status.
REQ-013 Port fail_count_o  out  CW=$clog2(NUM_VECTORS+1): count of failed vectors.
REQ-014 Port first_fail_o  out  IW: index of the lowest failing vector.
REQ-015 Port timeout_o  out  1: sticky flag, set when any core wait expires.

Function
REQ-016 FSM states are IDLE, FETCH, LOAD, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT, CHECK, DONE.
REQ-017 IDLE or DONE with start_i=1: clear the counters and all flags, set idx=0, and go to FETCH; start_i is ignored in every other state.
REQ-018 FETCH drives vec_addr_o=idx, then goes to LOAD; LOAD latches plain, key and cipher into internal registers.
REQ-019 ENC_REQ: core_v_o=1, core_decrypt_o=0, data=latched plain, key=latched key; on core_ready_i go to ENC_WAIT.
REQ-020 ENC_WAIT: on core_v_i, latch the result and compare it with the latched cipher; go to DEC_REQ if AES_KAT_DECRYPT_EN is defined, else go to CHECK.
REQ-021 DEC_REQ/DEC_WAIT: same handshake with core_decrypt_o=1 and data=encrypt result; the decrypt result is compared with the latched plain.
REQ-022 Payload stays stable while core_v_o=1 and core_ready_i=0; core_v_o falls in the cycle after the handshake.
REQ-023 A cycle counter resets on entry to each WAIT state; on reaching TIMEOUT_CYCLES without core_v_i, the vector fails, timeout_o is set, and the FSM goes to CHECK.
REQ-024 CHECK: a vector fails on any mismatch or timeout; on failure fail_count_o increments, and first_fail_o is loaded only when fail_count_o was 0.
REQ-025 CHECK: if idx==NUM_VECTORS-1 go to DONE, else increment idx and go to FETCH; idx never wraps.
REQ-026 DONE: done_o=1 and pass_o=(fail_count_o==0); both hold until the next start_i.
REQ-027 busy_o=1 in every state except IDLE and DONE.
REQ-028 core_v_i arriving outside a WAIT state is ignored.
REQ-029 core_v_i in the same cycle the timeout expires counts as a response, not a timeout.

Reset
REQ-030 Asserting reset_n_i at any time, including mid-run, forces IDLE with all outputs and counters at 0; core_v_o drops asynchronously.
REQ-031 After reset is released, the block stays in IDLE until start_i.

Configuration
REQ-032 Macro AES_KAT_DECRYPT_EN defined: each vector runs encrypt then decrypt, and both results must match.
REQ-033 Macro AES_KAT_DECRYPT_EN not defined: the DEC states are unreachable, core_decrypt_o is tied to 0, and only the encrypt result is checked.

Verification
REQ-034 KEY_W=256, NUM_VECTORS=1, plain 00112233445566778899aabbccddeeff, key 000102..1f, cipher 8ea2b7ca516745bfeafc49904b496089, golden core -> done_o=1, pass_o=1, fail_count_o=0.
REQ-035 4 vectors, core corrupts the encrypt result of vector 2 -> fail_count_o=1, first_fail_o=2, pass_o=0.
REQ-036 core_ready_i held low for 5 cycles -> core_data_o and core_key_o stay stable, and exactly one transfer is seen per request.
REQ-037 core never raises core_v_i on vector 1, TIMEOUT_CYCLES=8 -> timeout_o=1 after 8 wait cycles, the run continues, fail_count_o=1.
REQ-038 reset_n_i pulsed low during ENC_WAIT, then start_i -> all outputs 0, then a clean full run with pass_o=1.
REQ-039 Build with and without AES_KAT_DECRYPT_EN, KEY_W=128 FIPS-197 vector (key 000102..0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a) -> pass in both builds; core_decrypt_o is never 1 in the build without the macro.
